// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receive FIFO and its neighbours: receiver strobe,
// register-bank pop/control and the FIFO status. rx_timeout exists only with UART_RXFIFO_TIMEOUT_EN.
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          rx_perr;
    logic          rd_pop;
    logic          flush;
    logic          clr_overrun;
    logic [AW:0]   thresh;
    logic [7:0]    rd_data;
    logic          rd_perr;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          overrun;
    logic          irq;
`ifdef UART_RXFIFO_TIMEOUT_EN
    logic          rx_timeout;
`endif

    modport master (
`ifdef UART_RXFIFO_TIMEOUT_EN
        input  rx_timeout,
`endif
        output rx_done, rx_data, rx_perr, rd_pop, flush, clr_overrun, thresh,
        input  rd_data, rd_perr, empty, full, level, overrun, irq
    );

    modport slave (
`ifdef UART_RXFIFO_TIMEOUT_EN
        output rx_timeout,
`endif
        input  rx_done, rx_data, rx_perr, rd_pop, flush, clr_overrun, thresh,
        output rd_data, rd_perr, empty, full, level, overrun, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between UART receiver and register bank: show-ahead head, level/status, threshold irq.
// Optional idle timeout flag is compiled in with UART_RXFIFO_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);

    if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 256 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("uart_rx_fifo: illegal parameter combination");
    end

    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL   = (AW+1)'(1);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [AW:0]   level_q, level_nxt;
    logic          empty_q, full_q;
    logic          overrun_q, overrun_nxt;
    logic          irq_q, irq_nxt;
    logic [8:0]    head_q, head_nxt;
    logic          push, pop, overflow;
    logic          to_term;

    always_comb begin
        push       = bus.rx_done && (!full_q || bus.rd_pop) && !bus.flush;
        pop        = bus.rd_pop && !empty_q && !bus.flush;
        overflow   = bus.rx_done && full_q && !bus.rd_pop && !bus.flush;
        rd_ptr_inc = rd_ptr + AW'(1);

        level_nxt = level_q;
        if (bus.flush)
            level_nxt = '0;
        else if (push && !pop)
            level_nxt = level_q + ONE_LVL;
        else if (pop && !push)
            level_nxt = level_q - ONE_LVL;

        // Head register: read ahead on pop, bypass the incoming byte when it lands in an empty FIFO.
        // When the FIFO drains or is flushed the old head is simply held.
        head_nxt = head_q;
        if (pop) begin
            if (level_q > ONE_LVL)
                head_nxt = mem[rd_ptr_inc];
            else if (push)
                head_nxt = {bus.rx_perr, bus.rx_data};
        end else if (push && empty_q) begin
            head_nxt = {bus.rx_perr, bus.rx_data};
        end

        overrun_nxt = overflow || (overrun_q && !bus.clr_overrun);
        irq_nxt     = ((bus.thresh != '0) && (level_nxt >= bus.thresh)) || overrun_nxt || to_term;
    end

`ifdef UART_RXFIFO_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

    logic [15:0] idle_q, idle_nxt;
    logic        to_q, to_nxt;

    always_comb begin
        idle_nxt = idle_q;
        if (push || pop || bus.flush || empty_q)
            idle_nxt = '0;
        else if (idle_q != TO_LIM)
            idle_nxt = idle_q + 16'd1;

        to_nxt = to_q;
        if (pop || bus.flush)
            to_nxt = 1'b0;
        else if (idle_nxt == TO_LIM)
            to_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else begin
            idle_q <= idle_nxt;
            to_q   <= to_nxt;
        end
    end

    assign to_term        = to_nxt;
    assign bus.rx_timeout = to_q;
`else
    assign to_term = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.rx_perr, bus.rx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            head_q    <= '0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr_inc;
            end
            level_q   <= level_nxt;
            empty_q   <= (level_nxt == '0);
            full_q    <= (level_nxt == DEPTH_LVL);
            overrun_q <= overrun_nxt;
            irq_q     <= irq_nxt;
            head_q    <= head_nxt;
        end
    end

    assign bus.rd_data = head_q[7:0];
    assign bus.rd_perr = head_q[8];
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.level   = level_q;
    assign bus.overrun = overrun_q;
    assign bus.irq     = irq_q;

endmodule
